booth_radix4_seq_mul: RTL and testbench

//  Multi-cycle radix-4 (modified Booth) multiplier: WIDTH x WIDTH -> 2*WIDTH.

---
 rtl/booth_radix4_seq_mul.sv | 133 +++++++++++++
 tb/tb_booth_radix4_seq_mul.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_seq_mul.sv
// Sequential radix-4 (modified Booth) multiplier, WIDTH x WIDTH -> 2*WIDTH, valid/ready on both sides.
// Define BOOTH_SIGN_MODE_EN to add the signed_mode port; otherwise operands are always two's complement.
module booth_radix4_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
`ifdef BOOTH_SIGN_MODE_EN
    input  logic                 signed_mode,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N + 1);
    localparam int QW = WIDTH + 2;
    localparam int AW = WIDTH + 4;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
            $error("booth_radix4_seq_mul: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [QW-1:0]   m_reg;
    logic [QW-1:0]   q_reg;
    logic            q_1;
    logic [AW-1:0]   a_reg;
    logic [CW-1:0]   count;
    logic            sign_sel;
    logic [AW-1:0]   m_ext;
    logic [AW-1:0]   m_dbl;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   a_sum;

`ifdef BOOTH_SIGN_MODE_EN
    assign sign_sel = signed_mode;
`else
    assign sign_sel = 1'b1;
`endif

    assign in_ready = (state == IDLE);

    // Booth digit from the two low multiplier bits plus the bit shifted out last step.
    always_comb begin
        m_ext  = {{2{m_reg[QW-1]}}, m_reg};
        m_dbl  = {m_reg[QW-1], m_reg, 1'b0};
        addend = '0;
        case ({q_reg[1:0], q_1})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_dbl;
            3'b100:         addend = -m_dbl;
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        a_sum = a_reg + addend;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = RUN;
            RUN:     if (count == CW'(1)) next_state = DONE;
            DONE:    if (out_valid && out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE spends one cycle publishing {A,Q} before out_valid rises, giving the fixed N+1 latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reg     <= '0;
            q_reg     <= '0;
            q_1       <= 1'b0;
            a_reg     <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_reg <= sign_sel ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                          : {2'b00, multiplicand};
                        q_reg <= sign_sel ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                          : {2'b00, multiplier};
                        q_1   <= 1'b0;
                        a_reg <= '0;
                        count <= CW'(N);
                    end
                end
                RUN: begin
                    a_reg <= {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
                    q_reg <= {a_sum[1:0], q_reg[QW-1:2]};
                    q_1   <= q_reg[1];
                    count <= count - CW'(1);
                end
                DONE: begin
                    if (!out_valid) begin
                        product   <= {a_reg[WIDTH-3:0], q_reg};
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_radix4_seq_mul.sv
// Self-checking bench for booth_radix4_seq_mul: directed cases plus random pairs at WIDTH=8 and WIDTH=32
// against an arithmetic reference; exercises signed_mode only when BOOTH_SIGN_MODE_EN is defined.
module tb_booth_radix4_seq_mul;

    localparam int W  = 8;
    localparam int N8 = W / 2 + 1;
    localparam int WW = 32;
    localparam int NW = WW / 2 + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic          signed_mode;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] product;

    logic           in_valid_w;
    logic           in_ready_w;
    logic [WW-1:0]  mcand_w;
    logic [WW-1:0]  mplier_w;
    logic           signed_mode_w;
    logic           out_valid_w;
    logic           out_ready_w;
    logic [2*WW-1:0] product_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_radix4_seq_mul #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (mcand),
        .multiplier   (mplier),
`ifdef BOOTH_SIGN_MODE_EN
        .signed_mode  (signed_mode),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
    );

    booth_radix4_seq_mul #(.WIDTH(WW)) dut_wide (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid_w),
        .in_ready     (in_ready_w),
        .multiplicand (mcand_w),
        .multiplier   (mplier_w),
`ifdef BOOTH_SIGN_MODE_EN
        .signed_mode  (signed_mode_w),
`endif
        .out_valid    (out_valid_w),
        .out_ready    (out_ready_w),
        .product      (product_w)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference product: extend each w-bit operand to 64 bits, multiply, keep the low 2w bits.
    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                               input int w, input bit sm);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] full;
        ea = '0;
        eb = '0;
        for (int i = 0; i < 64; i++) begin
            ea[i] = (i < w) ? a[i] : (sm & a[w-1]);
            eb[i] = (i < w) ? b[i] : (sm & b[w-1]);
        end
        full = ea * eb;
        if (w < 32) full = full & ((64'd1 << (2 * w)) - 64'd1);
        return full;
    endfunction

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                                 input int stall, output logic [2*W-1:0] prod);
        int lat;
        logic [2*W-1:0] held;
        logic [63:0] exp_p;
        exp_p = refProduct({24'b0, a}, {24'b0, b}, W, sm);
        @(negedge clk);
        checkOutput("in_ready_idle", {63'b0, in_ready}, 64'd1);
        mcand = a;
        mplier = b;
        signed_mode = sm;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        signed_mode = ~sm;
        mcand = W'($urandom);
        mplier = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'(N8 + 1));
        checkOutput("product", {48'b0, product}, exp_p);
        held = product;
        for (int i = 0; i < stall; i++) begin
            in_valid = (i % 2 == 0);
            mcand = W'($urandom);
            mplier = W'($urandom);
            @(negedge clk);
            checkOutput("stall_out_valid", {63'b0, out_valid}, 64'd1);
            checkOutput("stall_product", {48'b0, product}, {48'b0, held});
            checkOutput("stall_in_ready", {63'b0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("accept_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("accept_in_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("product_hold", {48'b0, product}, {48'b0, held});
        prod = held;
    endtask

    task automatic applyStimulusWide(input logic [WW-1:0] a, input logic [WW-1:0] b, input bit sm);
        int lat;
        @(negedge clk);
        mcand_w = a;
        mplier_w = b;
        signed_mode_w = sm;
        in_valid_w = 1'b1;
        @(negedge clk);
        in_valid_w = 1'b0;
        signed_mode_w = ~sm;
        lat = 0;
        while (!out_valid_w && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("wide_latency", 64'(lat), 64'(NW + 1));
        checkOutput("wide_product", product_w, refProduct(a, b, WW, sm));
        out_ready_w = 1'b1;
        @(negedge clk);
        out_ready_w = 1'b0;
        checkOutput("wide_in_ready", {63'b0, in_ready_w}, 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2*W-1:0] p;
        int first_mode;
`ifdef BOOTH_SIGN_MODE_EN
        first_mode = 0;
`else
        first_mode = 1;
`endif
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        mcand = '0;
        mplier = '0;
        signed_mode = 1'b1;
        in_valid_w = 1'b0;
        out_ready_w = 1'b0;
        mcand_w = '0;
        mplier_w = '0;
        signed_mode_w = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd1);
        checkOutput("reset_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("reset_product", {48'b0, product}, 64'd0);
        checkOutput("reset_wide_in_ready", {63'b0, in_ready_w}, 64'd1);
        checkOutput("reset_wide_out_valid", {63'b0, out_valid_w}, 64'd0);
        checkOutput("reset_wide_product", product_w, 64'd0);
        rst = 1'b0;

        applyStimulus(8'd3, 8'd5, 1'b1, 0, p);
        checkOutput("signed_3x5", {48'b0, p}, 64'h000F);
        applyStimulus(8'hF9, 8'd6, 1'b1, 0, p);
        checkOutput("signed_m7x6", {48'b0, p}, 64'hFFD6);
        applyStimulus(8'h80, 8'h80, 1'b1, 0, p);
        checkOutput("signed_min_sq", {48'b0, p}, 64'h4000);
`ifdef BOOTH_SIGN_MODE_EN
        applyStimulus(8'hFF, 8'hFF, 1'b0, 0, p);
        checkOutput("unsigned_ff_sq", {48'b0, p}, 64'hFE01);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 0, p);
        checkOutput("signed_ff_sq", {48'b0, p}, 64'h0001);
`endif
        applyStimulus(8'h0B, 8'hF3, 1'b1, 10, p);
        checkOutput("stall_11xm13", {48'b0, p}, 64'hFF71);

        // Abort a multiplication in its third RUN cycle with an asynchronous reset.
        @(negedge clk);
        mcand = 8'd7;
        mplier = 8'd9;
        signed_mode = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrun_rst_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("midrun_rst_product", {48'b0, product}, 64'd0);
        checkOutput("midrun_rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'd2, 8'd2, 1'b1, 0, p);
        checkOutput("after_rst_2x2", {48'b0, p}, 64'h0004);

        for (int mode = first_mode; mode < 2; mode++) begin
            for (int i = 0; i < 1000; i++) begin
                applyStimulus(W'($urandom), W'($urandom), mode[0], int'($urandom_range(0, 2)), p);
            end
        end

        applyStimulusWide(32'h8000_0000, 32'h8000_0000, 1'b1);
        checkOutput("wide_min_sq", product_w, 64'h4000_0000_0000_0000);
`ifdef BOOTH_SIGN_MODE_EN
        applyStimulusWide(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checkOutput("wide_unsigned_ones", product_w, 64'hFFFF_FFFE_0000_0001);
`endif
        for (int mode = first_mode; mode < 2; mode++) begin
            for (int i = 0; i < 200; i++) begin
                applyStimulusWide($urandom, $urandom, mode[0]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
